// File: rtl/flow_pkg.sv
// rtl/flow_pkg.sv - flow unit shared types: op encodings, SR bit indices, FSM states
package flow_pkg;

    localparam int FLOW_ADDR_W = 20;

    // Status register bit positions: {T,S,Z,C}
    localparam int SR_C = 0;
    localparam int SR_Z = 1;
    localparam int SR_S = 2;
    localparam int SR_T = 3;

    typedef enum logic [2:0] {
        OP_TRAP = 3'd0,
        OP_NOP  = 3'd1,
        OP_JMP  = 3'd2,
        OP_JZ   = 3'd3,
        OP_JS   = 3'd4,
        OP_JZS  = 3'd5,
        OP_LDSR = 3'd6,
        OP_XSR  = 3'd7
    } flow_op_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_HALT = 2'd2
    } flow_state_e;

endpackage

// File: rtl/flow_cond.sv
// rtl/flow_cond.sv - jump condition evaluation from op and effective flags
module flow_cond
    import flow_pkg::*;
(
    input  flow_op_e   op,
    input  logic [2:0] sr_eff,
    output logic       taken
);

    // Only jump ops can be taken; everything else reports not-taken
    always_comb begin
        taken = 1'b0;
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = sr_eff[SR_Z];
            OP_JS:   taken = sr_eff[SR_S];
            OP_JZS:  taken = sr_eff[SR_Z] | sr_eff[SR_S];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flow_ctrl.sv
// rtl/flow_ctrl.sv - program-flow unit (PC, SR, trap FSM); optional FLOW_FLAG_BYPASS_EN
module flow_ctrl
    import flow_pkg::*;
#(
    parameter int                ADDR_W   = FLOW_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'('h10)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_target,
    input  logic              flag_we,
    input  logic              flag_carry,
    input  logic              flag_zero,
    input  logic              flag_sign,
    input  logic              trap_ret,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        sr,
    output logic [ADDR_W-1:0] epc,
    output logic              jump_taken,
    output logic              halted
);

    flow_state_e       state;
    flow_op_e          op;
    logic [2:0]        flags;
    logic [2:0]        flag_in;
    logic [2:0]        sr_eff;
    logic [ADDR_W-1:0] pc_inc;
    logic              accept;
    logic              taken;

    // Handshake, sequential PC and the flag view used for conditions
    always_comb begin
        op          = flow_op_e'(instr_op);
        instr_ready = (state != ST_HALT) && !trap_ret;
        accept      = instr_valid && instr_ready;
        pc_inc      = pc + ADDR_W'(1);
        flag_in     = {flag_sign, flag_zero, flag_carry};
`ifdef FLOW_FLAG_BYPASS_EN
        sr_eff      = flag_we ? flag_in : flags;
`else
        sr_eff      = flags;
`endif
    end

    // T bit mirrors the trap state; the other bits are the stored flags
    always_comb begin
        sr       = '0;
        sr[2:0]  = flags;
        sr[SR_T] = (state == ST_TRAP);
    end

    flow_cond u_cond (
        .op     (op),
        .sr_eff (sr_eff),
        .taken  (taken)
    );

    // PC, flags, EPC and trap FSM with registered pulse/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            pc         <= RESET_PC;
            flags      <= '0;
            epc        <= '0;
            jump_taken <= 1'b0;
            halted     <= 1'b0;
        end else begin
            jump_taken <= 1'b0;

            // SR writes from the instruction stream override the ALU strobe
            if (accept && op == OP_LDSR) begin
                flags <= instr_target[2:0];
            end else if (accept && op == OP_XSR) begin
                flags <= flags ^ instr_target[2:0];
            end else if (flag_we) begin
                flags <= flag_in;
            end

            if (state == ST_TRAP && trap_ret) begin
                pc    <= epc;
                state <= ST_RUN;
            end else if (accept) begin
                if (op == OP_TRAP) begin
                    if (state == ST_RUN) begin
                        epc   <= pc_inc;
                        pc    <= TRAP_VEC;
                        state <= ST_TRAP;
                    end else begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end else begin
                    pc         <= taken ? instr_target : pc_inc;
                    jump_taken <= taken;
                end
            end
        end
    end

endmodule

// File: tb/tb_flow_ctrl.sv
// tb/tb_flow_ctrl.sv - self-checking bench for flow_ctrl with directed and random steps
module tb_flow_ctrl;

    localparam logic [19:0] TVEC = 20'h00010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  instr_op = 3'd1;
    logic [19:0] instr_target = '0;
    logic        flag_we = 1'b0;
    logic        flag_carry = 1'b0;
    logic        flag_zero = 1'b0;
    logic        flag_sign = 1'b0;
    logic        trap_ret = 1'b0;
    logic [19:0] pc;
    logic [3:0]  sr;
    logic [19:0] epc;
    logic        jump_taken;
    logic        halted;

    int checks = 0;
    int failures = 0;

    // Reference machine state
    logic [19:0] m_pc;
    logic [2:0]  m_fl;
    logic [19:0] m_epc;
    bit          m_in_trap;
    bit          m_halt;
    bit          m_jt;
    int          jt_count;

    flow_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_target (instr_target),
        .flag_we      (flag_we),
        .flag_carry   (flag_carry),
        .flag_zero    (flag_zero),
        .flag_sign    (flag_sign),
        .trap_ret     (trap_ret),
        .pc           (pc),
        .sr           (sr),
        .epc          (epc),
        .jump_taken   (jump_taken),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
        chk({tag, ".sr"}, 32'(sr), 32'({m_in_trap, m_fl}));
        chk({tag, ".epc"}, 32'(epc), 32'(m_epc));
        chk({tag, ".jt"}, 32'(jump_taken), 32'(m_jt));
        chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        m_pc = 20'h0; m_fl = 3'b0; m_epc = 20'h0;
        m_in_trap = 0; m_halt = 0; m_jt = 0;
        check_all("reset_async");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock of stimulus; reference computed from the behavioural rules
    task automatic step(input bit v, input logic [2:0] op, input logic [19:0] tgt,
                        input bit fwe, input logic [2:0] fszc, input bit tr, input string tag);
        bit          rdy, acc, tk;
        logic [2:0]  cf;
        logic [19:0] n_pc, n_epc;
        logic [2:0]  n_fl;
        bit          n_trap, n_halt, n_jt;
        instr_valid = v; instr_op = op; instr_target = tgt;
        flag_we = fwe; {flag_sign, flag_zero, flag_carry} = fszc; trap_ret = tr;

        rdy = !m_halt && !tr;
        acc = v && rdy;
`ifdef FLOW_FLAG_BYPASS_EN
        cf = fwe ? fszc : m_fl;
`else
        cf = m_fl;
`endif
        n_pc = m_pc; n_epc = m_epc; n_fl = m_fl;
        n_trap = m_in_trap; n_halt = m_halt; n_jt = 0;
        if (tr && m_in_trap) begin
            n_pc = m_epc; n_trap = 0;
        end else if (acc) begin
            if (op == 3'd0) begin
                if (m_in_trap) begin n_halt = 1; n_trap = 0; end
                else begin n_epc = m_pc + 20'd1; n_pc = TVEC; n_trap = 1; end
            end else begin
                tk = (op == 3'd2) || (op == 3'd3 && cf[1]) || (op == 3'd4 && cf[2])
                     || (op == 3'd5 && (cf[1] || cf[2]));
                n_pc = tk ? tgt : m_pc + 20'd1;
                n_jt = tk;
            end
        end
        if (acc && op == 3'd6) n_fl = tgt[2:0];
        else if (acc && op == 3'd7) n_fl = m_fl ^ tgt[2:0];
        else if (fwe) n_fl = fszc;

        #1;
        chk({tag, ".ready"}, 32'(instr_ready), 32'(rdy));
        @(posedge clk); #1;
        m_pc = n_pc; m_epc = n_epc; m_fl = n_fl;
        m_in_trap = n_trap; m_halt = n_halt; m_jt = n_jt;
        if (jump_taken) jt_count++;
        check_all(tag);
        instr_valid = 0; flag_we = 0; trap_ret = 0;
    endtask

    task automatic idle(input string tag);
        step(0, 3'd1, 20'h0, 0, 3'b0, 0, tag);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        chk("reset.ready", 32'(instr_ready), 32'd1);

        // NOP x3 from reset
        jt_count = 0;
        step(1, 3'd1, 20'h0, 0, 3'b0, 0, "nop1");
        step(1, 3'd1, 20'h0, 0, 3'b0, 0, "nop2");
        step(1, 3'd1, 20'h0, 0, 3'b0, 0, "nop3");
        chk("nop.pc3", 32'(pc), 32'h3);
        chk("nop.no_jt", 32'(jt_count), 32'd0);

        // flag_we Z=1 then JZ
        step(0, 3'd1, 20'h0, 1, 3'b010, 0, "fz");
        jt_count = 0;
        step(1, 3'd3, 20'h00ABC, 0, 3'b0, 0, "jz");
        chk("jz.pc", 32'(pc), 32'h00ABC);
        idle("jz.idle");
        chk("jz.one_pulse", 32'(jt_count), 32'd1);

        // JZS at pc=5, not taken then taken
        step(1, 3'd2, 20'h00005, 0, 3'b0, 0, "jmp5");
        step(1, 3'd6, 20'h0, 0, 3'b0, 0, "clr");
        step(1, 3'd2, 20'h00005, 0, 3'b0, 0, "jmp5b");
        step(1, 3'd5, 20'h00123, 0, 3'b0, 0, "jzs_nt");
        chk("jzs_nt.pc", 32'(pc), 32'h6);
        step(1, 3'd6, 20'h00004, 0, 3'b0, 0, "lds");
        step(1, 3'd2, 20'h00005, 0, 3'b0, 0, "jmp5c");
        step(1, 3'd5, 20'h00123, 0, 3'b0, 0, "jzs_t");
        chk("jzs_t.pc", 32'(pc), 32'h00123);

        // PC wrap
        step(1, 3'd2, 20'hFFFFF, 0, 3'b0, 0, "jmpmax");
        step(1, 3'd1, 20'h0, 0, 3'b0, 0, "wrap");
        chk("wrap.pc", 32'(pc), 32'h0);

        // LDSR wins over flag_we, then XSR
        step(1, 3'd6, 20'h00005, 1, 3'b010, 0, "ldsr");
        chk("ldsr.sr", 32'(sr), 32'h5);
        step(1, 3'd7, 20'h00007, 0, 3'b0, 0, "xsr");
        chk("xsr.sr", 32'(sr), 32'h2);

        // Trap entry/return, then double fault
        step(1, 3'd2, 20'h00007, 0, 3'b0, 0, "jmp7");
        step(1, 3'd0, 20'h0, 0, 3'b0, 0, "trap");
        chk("trap.pc", 32'(pc), 32'(TVEC));
        chk("trap.epc", 32'(epc), 32'h8);
        chk("trap.t", 32'(sr[3]), 32'd1);
        step(1, 3'd1, 20'h0, 0, 3'b0, 1, "tret");
        chk("tret.pc", 32'(pc), 32'h8);
        chk("tret.t", 32'(sr[3]), 32'd0);
        step(0, 3'd1, 20'h0, 0, 3'b0, 1, "tret_run");
        step(1, 3'd0, 20'h0, 0, 3'b0, 0, "trapA");
        step(1, 3'd0, 20'h0, 0, 3'b0, 0, "trapB");
        chk("halt.halted", 32'(halted), 32'd1);
        step(1, 3'd2, 20'h00333, 0, 3'b0, 0, "halt_jmp");
        step(0, 3'd1, 20'h0, 0, 3'b0, 1, "halt_tret");
        chk("halt.ready", 32'(instr_ready), 32'd0);
        do_reset();

        // Flag hazard: same-cycle flag_we Z=1 with JZ
        step(1, 3'd6, 20'h0, 0, 3'b0, 0, "clr2");
        step(1, 3'd3, 20'h00444, 1, 3'b010, 0, "byp");
`ifdef FLOW_FLAG_BYPASS_EN
        chk("byp.pc", 32'(pc), 32'h00444);
`else
        chk("byp.pc", 32'(pc), 32'h2);
`endif

        // Randomized run against the reference
        for (int i = 0; i < 400; i++) begin
            if (m_halt && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     3'($urandom_range(0, 7)),
                     20'($urandom),
                     $urandom_range(0, 2) == 0,
                     3'($urandom_range(0, 7)),
                     $urandom_range(0, 7) == 0,
                     "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
